// File: rtl/dbus_arbiter.sv
// dbus_arbiter: round-robin arbiter sharing the SoC data bus between
// CPU0 (master 0) and up to three DMA / video-fetch masters.
//
// Ports:
//   i_Clk, i_Reset          clock, asynchronous active-high reset
//   i_M_Req / i_M_Lock      per-master request and grant-lock
//   o_M_Gnt                 one-hot registered grant
//   i_M_Address/ByteEn/Read/Write/WriteData
//                           per-master bus fields, packed master-major
//   o_M_ReadData            shared read data to all masters
//   o_M_WaitRequest         per-master stall
//   o_S_*                   shared DBus towards address decode/slaves
//   i_S_ReadData            OR-tree slave read data
//   i_S_WaitRequest         OR-tree slave wait request
//   o_Timeout               stall-timeout pulse
//
// Optional feature: define DBUS_ARB_TIMEOUT_EN to enable the stall
// timeout (TIMEOUT_CYCLES stalled cycles abort the transfer with
// read data 32'hDEADBEEF). Without it o_Timeout is tied 0.

module dbus_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      i_Clk,
    input  logic                      i_Reset,
    input  logic [NUM_MASTERS-1:0]    i_M_Req,
    input  logic [NUM_MASTERS-1:0]    i_M_Lock,
    output logic [NUM_MASTERS-1:0]    o_M_Gnt,
    input  logic [30*NUM_MASTERS-1:0] i_M_Address,
    input  logic [4*NUM_MASTERS-1:0]  i_M_ByteEn,
    input  logic [NUM_MASTERS-1:0]    i_M_Read,
    input  logic [NUM_MASTERS-1:0]    i_M_Write,
    input  logic [32*NUM_MASTERS-1:0] i_M_WriteData,
    output logic [31:0]               o_M_ReadData,
    output logic [NUM_MASTERS-1:0]    o_M_WaitRequest,
    output logic [29:0]               o_S_Address,
    output logic [3:0]                o_S_ByteEn,
    output logic                      o_S_Read,
    output logic                      o_S_Write,
    output logic [31:0]               o_S_WriteData,
    input  logic [31:0]               i_S_ReadData,
    input  logic                      i_S_WaitRequest,
    output logic                      o_Timeout
);

    localparam int N = NUM_MASTERS;
    localparam logic [1:0] LAST_RST = 2'(NUM_MASTERS - 1);

    // Elaboration-time range checks on the configuration.
    if (NUM_MASTERS < 2 || NUM_MASTERS > 4) begin : g_bad_masters
        $error("dbus_arbiter: NUM_MASTERS must be 2..4");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("dbus_arbiter: TIMEOUT_CYCLES must be 1..65535");
    end

    logic [N-1:0] r_Gnt;
    logic [1:0]   r_Last;

    logic         busy;
    logic         fire;
    logic         busy_hold;
    logic         lock_hold;
    logic [N-1:0] nxt_gnt;
    logic [1:0]   nxt_last;
    logic         found;

    assign o_M_Gnt = r_Gnt;

    // Grant is one-hot or zero, so a plain priority mux over the grant
    // bits selects the owner, and an empty grant leaves everything 0.
    always_comb begin
        o_S_Address   = '0;
        o_S_ByteEn    = '0;
        o_S_Read      = 1'b0;
        o_S_Write     = 1'b0;
        o_S_WriteData = '0;
        for (int i = 0; i < N; i++) begin
            if (r_Gnt[i]) begin
                o_S_Address   = i_M_Address[30*i +: 30];
                o_S_ByteEn    = i_M_ByteEn[4*i +: 4];
                o_S_Read      = i_M_Read[i];
                o_S_Write     = i_M_Write[i];
                o_S_WriteData = i_M_WriteData[32*i +: 32];
            end
        end
    end

    assign busy = (o_S_Read | o_S_Write) & i_S_WaitRequest;

    // Masters strobing without the grant are stalled; the owner sees the
    // slave stall, except when a timeout aborts its transfer.
    always_comb begin
        o_M_WaitRequest = '0;
        for (int i = 0; i < N; i++) begin
            if (r_Gnt[i])
                o_M_WaitRequest[i] = i_S_WaitRequest & ~fire;
            else
                o_M_WaitRequest[i] = i_M_Read[i] | i_M_Write[i];
        end
    end

    assign o_M_ReadData = fire ? 32'hDEADBEEF : i_S_ReadData;

    assign lock_hold = |(r_Gnt & i_M_Lock & i_M_Req);
    // A timed-out transfer counts as completed for arbitration.
    assign busy_hold = busy & ~fire;

    // Round-robin scan: candidate priority starts just above r_Last.
    always_comb begin
        nxt_gnt  = '0;
        nxt_last = r_Last;
        found    = 1'b0;
        for (int k = 1; k <= N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!found && i_M_Req[i] &&
                    (((int'(r_Last) + k) % N) == i)) begin
                    found      = 1'b1;
                    nxt_gnt[i] = 1'b1;
                    nxt_last   = 2'(i);
                end
            end
        end
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_Gnt  <= '0;
            r_Last <= LAST_RST;
        end else if (!busy_hold && !lock_hold) begin
            r_Gnt <= nxt_gnt;
            // An empty scan keeps the rotation point.
            if (found)
                r_Last <= nxt_last;
        end
    end

`ifdef DBUS_ARB_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] r_Cnt;

    // r_Cnt holds the number of stalled cycles already seen, so the
    // TIMEOUT_CYCLES-th stalled cycle is the one where it equals limit-1.
    assign fire      = busy & (r_Cnt == TO_LAST);
    assign o_Timeout = fire;

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset)
            r_Cnt <= '0;
        else if (busy && !fire)
            r_Cnt <= r_Cnt + 16'd1;
        else
            r_Cnt <= '0;
    end
`else
    assign fire      = 1'b0;
    assign o_Timeout = 1'b0;
`endif

endmodule

// File: tb/tb_dbus_arbiter.sv
// tb_dbus_arbiter: directed scoreboard bench for dbus_arbiter, N=2.
// Driver pushes expected bus snapshots; a monitor pops and compares.

module tb_dbus_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  lock;
    logic [1:0]  gnt;
    logic [59:0] addr;
    logic [7:0]  be;
    logic [1:0]  rd;
    logic [1:0]  wr;
    logic [63:0] wd;
    logic [31:0] m_rdata;
    logic [1:0]  m_wait;
    logic [29:0] s_addr;
    logic [3:0]  s_be;
    logic        s_rd;
    logic        s_wr;
    logic [31:0] s_wd;
    logic [31:0] s_rdata;
    logic        s_wait;
    logic        to;

    dbus_arbiter #(
        .NUM_MASTERS   (2),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .i_Clk          (clk),
        .i_Reset        (rst),
        .i_M_Req        (req),
        .i_M_Lock       (lock),
        .o_M_Gnt        (gnt),
        .i_M_Address    (addr),
        .i_M_ByteEn     (be),
        .i_M_Read       (rd),
        .i_M_Write      (wr),
        .i_M_WriteData  (wd),
        .o_M_ReadData   (m_rdata),
        .o_M_WaitRequest(m_wait),
        .o_S_Address    (s_addr),
        .o_S_ByteEn     (s_be),
        .o_S_Read       (s_rd),
        .o_S_Write      (s_wr),
        .o_S_WriteData  (s_wd),
        .i_S_ReadData   (s_rdata),
        .i_S_WaitRequest(s_wait),
        .o_Timeout      (to)
    );

    typedef struct {
        logic [1:0]  gnt;
        logic        srd;
        logic        swr;
        logic [1:0]  mw;
        logic        to;
        logic [29:0] sa;
        logic [3:0]  sbe;
        logic [31:0] swd;
        logic [31:0] rdata;
        string       nm;
    } exp_t;

    exp_t q[$];
    event chk_ev;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", nm, act, exp);
        end
    endtask

    // Expected snapshot from hand-given grant/strobe/stall values; bus
    // fields follow from the current drive of the expected owner.
    task automatic push_exp(input logic [1:0] eg, input logic [1:0] emw,
                            input logic esr, input logic esw,
                            input logic eto, input string nm);
        exp_t e;
        e.gnt   = eg;
        e.srd   = esr;
        e.swr   = esw;
        e.mw    = emw;
        e.to    = eto;
        e.sa    = eg[0] ? addr[29:0] : (eg[1] ? addr[59:30] : 30'h0);
        e.sbe   = eg[0] ? be[3:0]    : (eg[1] ? be[7:4]     : 4'h0);
        e.swd   = eg[0] ? wd[31:0]   : (eg[1] ? wd[63:32]   : 32'h0);
        e.rdata = eto ? 32'hDEADBEEF : s_rdata;
        e.nm    = nm;
        q.push_back(e);
    endtask

    task automatic step(input logic r, input logic [1:0] rq,
                        input logic [1:0] lk, input logic [1:0] r_,
                        input logic [1:0] w_, input logic sw,
                        input logic [1:0] eg, input logic [1:0] emw,
                        input logic esr, input logic esw,
                        input logic eto, input string nm);
        @(posedge clk);
        #1;
        cyc++;
        rst     = r;
        req     = rq;
        lock    = lk;
        rd      = r_;
        wr      = w_;
        s_wait  = sw;
        addr    = {30'h2000 + 30'(cyc), 30'h100 + 30'(cyc)};
        wd      = {32'h2222_0000 + 32'(cyc), 32'h1111_0000 + 32'(cyc)};
        be      = 8'hC3;
        s_rdata = 32'hA500_0000 + 32'(cyc);
        push_exp(eg, emw, esr, esw, eto, nm);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk or chk_ev);
            while (q.size() > 0) begin
                e = q.pop_front();
                chk({e.nm, ".gnt"},   32'(gnt),     32'(e.gnt));
                chk({e.nm, ".srd"},   32'(s_rd),    32'(e.srd));
                chk({e.nm, ".swr"},   32'(s_wr),    32'(e.swr));
                chk({e.nm, ".mwait"}, 32'(m_wait),  32'(e.mw));
                chk({e.nm, ".to"},    32'(to),      32'(e.to));
                chk({e.nm, ".saddr"}, 32'(s_addr),  32'(e.sa));
                chk({e.nm, ".sbe"},   32'(s_be),    32'(e.sbe));
                chk({e.nm, ".swd"},   s_wd,         e.swd);
                chk({e.nm, ".rdata"}, m_rdata,      e.rdata);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req = '0; lock = '0; rd = '0; wr = '0;
        addr = '0; be = '0; wd = '0; s_rdata = '0; s_wait = 1'b0;

        // reset state and first grant
        step(1, 2'b00, 2'b00, 2'b10, 2'b00, 0, 2'b00, 2'b10, 0, 0, 0, "rst_mw");
        step(1, 2'b01, 2'b00, 2'b01, 2'b00, 0, 2'b00, 2'b01, 0, 0, 0, "rst_hold");
        step(0, 2'b01, 2'b00, 2'b01, 2'b00, 0, 2'b00, 2'b01, 0, 0, 0, "first_req");
        step(0, 2'b01, 2'b00, 2'b01, 2'b00, 0, 2'b01, 2'b00, 1, 0, 0, "first_gnt");
        step(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 2'b01, 2'b00, 0, 0, 0, "drop_req");
        step(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0, "idle");

        // contention, 0-wait reads alternate
        step(0, 2'b11, 2'b00, 2'b11, 2'b00, 0, 2'b00, 2'b11, 0, 0, 0, "cont_req");
        step(0, 2'b11, 2'b00, 2'b11, 2'b00, 0, 2'b10, 2'b01, 1, 0, 0, "cont_a");
        step(0, 2'b11, 2'b00, 2'b11, 2'b00, 0, 2'b01, 2'b10, 1, 0, 0, "cont_b");
        step(0, 2'b11, 2'b00, 2'b11, 2'b00, 0, 2'b10, 2'b01, 1, 0, 0, "cont_c");
        step(0, 2'b11, 2'b00, 2'b11, 2'b00, 0, 2'b01, 2'b10, 1, 0, 0, "cont_d");

        // master 1 write stalled for 5 cycles
        repeat (5)
            step(0, 2'b11, 2'b00, 2'b01, 2'b10, 1, 2'b10, 2'b11, 0, 1, 0, "stall");
        step(0, 2'b11, 2'b00, 2'b01, 2'b10, 0, 2'b10, 2'b01, 0, 1, 0, "stall_end");
        step(0, 2'b01, 2'b00, 2'b01, 2'b00, 0, 2'b01, 2'b00, 1, 0, 0, "after_stall");

        // lock keeps master 0 for 3 transfers
        step(0, 2'b11, 2'b01, 2'b11, 2'b00, 0, 2'b01, 2'b10, 1, 0, 0, "lock1");
        step(0, 2'b11, 2'b01, 2'b11, 2'b00, 0, 2'b01, 2'b10, 1, 0, 0, "lock2");
        step(0, 2'b11, 2'b00, 2'b11, 2'b00, 0, 2'b01, 2'b10, 1, 0, 0, "lock3");
        step(0, 2'b10, 2'b00, 2'b10, 2'b00, 0, 2'b10, 2'b00, 1, 0, 0, "lock_rel");
        step(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 2'b10, 2'b00, 0, 0, 0, "drop_req2");
        step(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0, "idle2");

        // asynchronous reset during a stalled read
        step(0, 2'b01, 2'b00, 2'b01, 2'b00, 0, 2'b00, 2'b01, 0, 0, 0, "r_req");
        step(0, 2'b01, 2'b00, 2'b01, 2'b00, 1, 2'b01, 2'b01, 1, 0, 0, "r_stall");
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        push_exp(2'b00, 2'b01, 0, 0, 0, "async_rst");
        -> chk_ev;
        step(0, 2'b11, 2'b00, 2'b11, 2'b00, 0, 2'b00, 2'b11, 0, 0, 0, "post_rst");
        step(0, 2'b11, 2'b00, 2'b11, 2'b00, 0, 2'b01, 2'b10, 1, 0, 0, "last_reset");

        // permanent slave stall on master 1
        repeat (7)
            step(0, 2'b11, 2'b00, 2'b11, 2'b00, 1, 2'b10, 2'b11, 1, 0, 0, "to_stall");
`ifdef DBUS_ARB_TIMEOUT_EN
        step(0, 2'b11, 2'b00, 2'b11, 2'b00, 1, 2'b10, 2'b01, 1, 0, 1, "to_fire");
        step(0, 2'b11, 2'b00, 2'b11, 2'b00, 1, 2'b01, 2'b11, 1, 0, 0, "to_rotate");
        step(0, 2'b11, 2'b00, 2'b11, 2'b00, 0, 2'b01, 2'b10, 1, 0, 0, "to_release");
`else
        step(0, 2'b11, 2'b00, 2'b11, 2'b00, 1, 2'b10, 2'b11, 1, 0, 0, "no_to");
        step(0, 2'b11, 2'b00, 2'b11, 2'b00, 1, 2'b10, 2'b11, 1, 0, 0, "no_to_hold");
        step(0, 2'b11, 2'b00, 2'b11, 2'b00, 0, 2'b10, 2'b01, 1, 0, 0, "stall_release");
`endif
        step(0, 2'b00, 2'b00, 2'b00, 2'b00, 0,
`ifdef DBUS_ARB_TIMEOUT_EN
             2'b10,
`else
             2'b01,
`endif
             2'b00, 0, 0, 0, "final");

        @(negedge clk);
        #1;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dbus_arbiter.md
# dbus_arbiter

Round-robin arbiter sharing the single SoC data bus (DBus) between up to four bus masters: CPU0, plus DMA and video-fetch masters. It replaces the single-flop CPU0 grant register at the top level. It runs the request-in-E / grant-in-M handshake, muxes the granted master onto the shared DBus, and holds the grant while the addressed slave stalls with WaitRequest. The shared DBus outputs feed the existing address decode and slave read-data/WaitRequest OR-trees unchanged.

## Interface
Parameters:
- NUM_MASTERS, 2: number of masters (2..4); index 0 is CPU0.
- TIMEOUT_CYCLES, 255: stall limit used only when DBUS_ARB_TIMEOUT_EN is defined (1..65535).

Ports (N = NUM_MASTERS):
- i_Clk  in  1  system clock (w_SysClk domain); the block has one clock.
- i_Reset  in  1  reset, asynchronous, active-high.
- i_M_Req  in  N  per-master bus request (CPU drives this from its E stage).
- i_M_Lock  in  N  keep grant across consecutive transfers (atomic sequences).
- o_M_Gnt  out  N  one-hot registered grant (CPU samples this in its M stage).
- i_M_Address  in  30*N  word address, master i at bits [30i+29:30i].
- i_M_ByteEn  in  4*N  byte enables.
- i_M_Read  in  N  read strobe.
- i_M_Write  in  N  write strobe.
- i_M_WriteData  in  32*N  write data.
- o_M_ReadData  out  32  shared read data, broadcast to all masters.
- o_M_WaitRequest  out  N  per-master stall.
- o_S_Address  out  30  shared DBus address.
- o_S_ByteEn  out  4  shared DBus byte enables.
- o_S_Read  out  1  shared DBus read strobe.
- o_S_Write  out  1  shared DBus write strobe.
- o_S_WriteData  out  32  shared DBus write data.
- i_S_ReadData  in  32  OR-tree slave read data.
- i_S_WaitRequest  in  1  OR-tree slave wait request.
- o_Timeout  out  1  one-cycle stall-timeout pulse; tied 0 without the macro.

## Operation
- State:
  - r_Gnt: N-bit one-hot or all-zero.
  - r_Last: index of the most recent grant, 2 bits.
- Bus mux:
  - o_S_* carry the fields of the master whose r_Gnt bit is set.
  - When r_Gnt is 0, all o_S_* are 0.
  - o_S_Read = Read[g] & Gnt[g] and o_S_Write = Write[g] & Gnt[g], where g is the granted index.
- Stall routing: o_M_WaitRequest[i] = Gnt[i] ? i_S_WaitRequest : (Read[i] | Write[i]).
  - A non-granted master that strobes the bus is stalled.
- Read data: o_M_ReadData = i_S_ReadData, unmodified. Masters sample it only while granted and not stalled.
- Busy: Busy = (o_S_Read | o_S_Write) & i_S_WaitRequest.
- Grant update, evaluated at each posedge in this priority order:
  1. Busy: hold r_Gnt and r_Last.
  2. The granted master has Lock & Req: hold.
  3. Otherwise: r_Gnt selects the first requester scanning from r_Last+1 upward, wrapping modulo N. r_Last takes that index. If no master requests, r_Gnt = 0 and r_Last is unchanged.
- Fairness:
  - A continuously requesting master without Lock loses the grant after one completed transfer if any other master is requesting.
  - With a single requester, that master is re-granted every cycle.
- Simultaneous requests rotate fairly. After reset, r_Last = N-1, so master 0 (CPU0) wins the first tie.

## Timing
- Reset values: r_Gnt = 0, r_Last = N-1, timeout counter 0, o_Timeout 0.
  - All o_S_* are therefore 0.
  - o_M_WaitRequest[i] = Read[i] | Write[i].
  - Reset is asynchronous. Assertion mid-transfer drops the grant and the bus strobes immediately, with no completion to the master.
- Grant latency: Req at cycle t (bus idle) gives Gnt at t+1. The master drives the transfer at t+1. A 0-wait slave completes at t+1.
- The grant never changes in a cycle that ends with Busy = 1. The master/slave pairing stays fixed for the whole stalled transfer.
- Handover: the next master's grant appears in the cycle after the current transfer's final (non-waited) cycle. There are no dead cycles between back-to-back transfers.
- Dropping Req while granted with no strobe releases the grant at the next edge.

## Configuration
- Macro: DBUS_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit counter increments on every Busy cycle and clears on any non-Busy cycle.
  - When the count reaches TIMEOUT_CYCLES while Busy, in that cycle:
    - o_M_WaitRequest of the granted master is forced to 0.
    - o_M_ReadData is forced to 32'hDEADBEEF.
    - o_Timeout pulses high for one cycle.
    - The counter clears.
  - At the following edge the arbiter re-arbitrates as if the transfer completed.
- Undefined: no counter; o_Timeout is tied 0; a slave stall can hold the bus indefinitely.

## Test plan
- Reset: with only master 0 requesting after reset, Gnt = 2'b00 in the reset cycle and 2'b01 one cycle after Req.
- Contention: N=2, both masters request continuously with 0-wait reads. Gnt alternates 01,10,01,10 and each master completes exactly one read per two cycles.
- Stall hold: master 1 writes to a slave asserting WaitRequest for 5 cycles while master 0 requests. Gnt stays 10 for all 6 cycles, o_S_Write stays high, and master 0 sees WaitRequest = 1. Master 0 is granted on the following cycle.
- Lock: master 0 asserts Lock for 3 back-to-back 0-wait transfers while master 1 requests. Gnt stays 01 for 3 transfers, then moves to 10 one cycle after Lock drops.
- Reset mid-transfer: assert i_Reset during a stalled read. o_S_Read and Gnt go to 0 in the same cycle without a clock edge, and r_Last returns to N-1.
- Timeout (DBUS_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES = 8): the slave holds WaitRequest permanently. At the 8th stalled cycle the master sees WaitRequest = 0, read data 32'hDEADBEEF and o_Timeout = 1 for one cycle. The grant then rotates to the other requester.
